// File: rtl/uart_rx_frame_if.sv
// Received-byte handshake between uart_rx_frame (master) and its consumer (slave).
// With UART_RX_PARITY_EN defined the bundle also carries the parity_err pulse.
interface uart_rx_frame_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ack;
    logic                 frame_err;
    logic                 overrun;
`ifdef UART_RX_PARITY_EN
    logic                 parity_err;

    modport master (output rx_data, rx_valid, frame_err, overrun, parity_err, input rx_ack);
    modport slave  (input rx_data, rx_valid, frame_err, overrun, parity_err, output rx_ack);
`else
    modport master (output rx_data, rx_valid, frame_err, overrun, input rx_ack);
    modport slave  (input rx_data, rx_valid, frame_err, overrun, output rx_ack);
`endif
endinterface

// File: rtl/uart_rx_frame.sv
// UART receive framer: start detect, mid-bit sampling on 16x ticks, LSB-first assembly.
// Optional parity bit between data and stop when UART_RX_PARITY_EN is defined.
module uart_rx_frame #(
    parameter int DATA_BITS = 8,
    parameter int OSR       = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic rx_clk,
    input  logic rxd,
`ifdef UART_RX_PARITY_EN
    input  logic parity_odd,
`endif
    output logic busy,
    uart_rx_frame_if.master rx_if
);
    localparam int CNT_W = $clog2(OSR);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OSR / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP
`ifdef UART_RX_PARITY_EN
        , S_PARITY
`endif
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           rxd_sync_q;
    logic                 rx_clk_q;
    logic [CNT_W-1:0]     tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 parity_err_d;
    logic                 rxs, tick, stop_sample, valid_left, par_bad;

    assign rxs         = rxd_sync_q[1];
    assign tick        = rx_clk && !rx_clk_q;
    assign stop_sample = tick && (state_q == S_STOP) && (tick_cnt_q == CNT_LAST);

`ifdef UART_RX_PARITY_EN
    logic parity_q, parity_d, parity_err_q;

    assign par_bad          = (^shift_q) ^ parity_q ^ parity_odd;
    assign rx_if.parity_err = parity_err_q;

    always_ff @(posedge clk) begin
        parity_q <= parity_d;
        if (!reset_n) parity_err_q <= 1'b0;
        else          parity_err_q <= parity_err_d;
    end
`else
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            rxd_sync_q  <= 2'b11;
            rx_clk_q    <= 1'b0;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rxd_sync_q  <= {rxd_sync_q[0], rxd};
            rx_clk_q    <= rx_clk;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
`ifdef UART_RX_PARITY_EN
        parity_d   = parity_q;
`endif
        if (tick) begin
            unique case (state_q)
                S_IDLE: begin
                    if (!rxs) begin
                        state_d    = S_START;
                        tick_cnt_d = '0;
                    end
                end
                S_START: begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                    // Mid-start check rejects glitches shorter than half a bit
                    if (tick_cnt_q == CNT_HALF) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = rxs ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    tick_cnt_d = (tick_cnt_q == CNT_LAST) ? '0 : tick_cnt_q + 1'b1;
                    if (tick_cnt_q == CNT_LAST) begin
                        shift_d   = {rxs, shift_q[DATA_BITS-1:1]};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    tick_cnt_d = (tick_cnt_q == CNT_LAST) ? '0 : tick_cnt_q + 1'b1;
                    if (tick_cnt_q == CNT_LAST) begin
                        parity_d = rxs;
                        state_d  = S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    tick_cnt_d = (tick_cnt_q == CNT_LAST) ? '0 : tick_cnt_q + 1'b1;
                    // Leaving at mid-stop leaves half a bit to catch the next start edge
                    if (tick_cnt_q == CNT_LAST) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy         = (state_q != S_IDLE);
        valid_left   = rx_valid_q && !rx_if.rx_ack;
        rx_valid_d   = valid_left;
        rx_data_d    = rx_data_q;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;
        parity_err_d = 1'b0;
        // Ack is applied before completion, so a same-cycle ack frees the slot
        if (stop_sample) begin
            frame_err_d  = !rxs;
            parity_err_d = par_bad;
            if (rxs && !par_bad) begin
                if (valid_left) begin
                    overrun_d = 1'b1;
                end else begin
                    rx_data_d  = shift_q;
                    rx_valid_d = 1'b1;
                end
            end
        end
    end

    assign rx_if.rx_data   = rx_data_q;
    assign rx_if.rx_valid  = rx_valid_q;
    assign rx_if.frame_err = frame_err_q;
    assign rx_if.overrun   = overrun_q;
endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed plus randomized bench for uart_rx_frame; the expected outcome of each
// frame comes from a frame-level model of the handshake and error rules.
module tb_uart_rx_frame;
    localparam int DATA_BITS = 8;
    localparam int OSR       = 16;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_BITS  = 1;
`else
    localparam int PAR_BITS  = 0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic rx_clk = 1'b0;
    logic rxd = 1'b1;
    logic busy;
`ifdef UART_RX_PARITY_EN
    logic p_odd = 1'b0;
`endif

    uart_rx_frame_if #(.DATA_BITS(DATA_BITS)) rx_if ();

    uart_rx_frame #(.DATA_BITS(DATA_BITS), .OSR(OSR)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .rx_clk  (rx_clk),
        .rxd     (rxd),
`ifdef UART_RX_PARITY_EN
        .parity_odd (p_odd),
`endif
        .busy    (busy),
        .rx_if   (rx_if)
    );

    always #5 clk = ~clk;

    int vecs = 0, errs = 0;
    int cyc = 0, half_per = 1, phase = 0, hold_cnt = 0;
    int tick_no = 0, rise_cyc = 0, lat = -1, ack_tick = -1;
    bit ack_armed = 1'b0, prev_valid = 1'b0, busy_prev = 1'b0;
    int n_ferr = 0, n_ovr = 0, m_ferr = 0, m_ovr = 0;
`ifdef UART_RX_PARITY_EN
    int n_perr = 0, m_perr = 0;
`endif
    logic [7:0] m_data = 8'h00;
    bit m_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clk period: observe outputs at negedge, then advance the rx_clk pattern.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (rx_if.frame_err === 1'b1) n_ferr++;
        if (rx_if.overrun === 1'b1) n_ovr++;
`ifdef UART_RX_PARITY_EN
        if (rx_if.parity_err === 1'b1) n_perr++;
`endif
        if (rx_if.rx_valid === 1'b1 && !prev_valid) lat = cyc - rise_cyc;
        prev_valid = (rx_if.rx_valid === 1'b1);
        // Stop bit is sampled 1/2 + data(+parity) + 1 bits after the detecting tick
        if (busy === 1'b1 && !busy_prev && ack_armed)
            ack_tick = tick_no + OSR / 2 + (DATA_BITS + PAR_BITS) * OSR + OSR;
        busy_prev = (busy === 1'b1);
        rx_if.rx_ack = 1'b0;
        if (hold_cnt > 0) begin
            hold_cnt--;
        end else begin
            phase++;
            if (phase >= half_per) begin
                phase = 0;
                rx_clk = ~rx_clk;
                if (rx_clk) begin
                    tick_no++;
                    rise_cyc = cyc;
                    if (ack_armed && tick_no == ack_tick) rx_if.rx_ack = 1'b1;
                end
            end
        end
    endtask

    task automatic wait_rises(input int n);
        int t;
        t = tick_no + n;
        while (tick_no < t) step();
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        wait_rises(OSR);
    endtask

    task automatic do_ack();
        rx_if.rx_ack = 1'b1;
        step();
        m_valid = 1'b0;
    endtask

    task automatic model_frame(input logic [7:0] data, input bit par_ok, input bit stop_ok,
                               input bit acked);
        if (acked) m_valid = 1'b0;
        if (!stop_ok) m_ferr++;
`ifdef UART_RX_PARITY_EN
        if (!par_ok) m_perr++;
`endif
        if (stop_ok && par_ok) begin
            if (m_valid) m_ovr++;
            else begin
                m_data  = data;
                m_valid = 1'b1;
            end
        end
    endtask

    task automatic frame(input logic [7:0] data, input bit flip, input bit stop_ok,
                         input int idle_bits, input bit acked, input int freeze_at);
        bit par_ok;
        par_ok = !(flip && PAR_BITS != 0);
        ack_armed = acked;
        ack_tick  = -1;
        send_bit(1'b0);
        for (int i = 0; i < DATA_BITS; i++) begin
            if (i == freeze_at) begin
                rxd = data[i];
                hold_cnt = 200;
                repeat (100) step();
                check("freeze_busy", 32'(busy), 32'd1);
                check("freeze_valid", 32'(rx_if.rx_valid), 32'(m_valid));
            end
            send_bit(data[i]);
        end
`ifdef UART_RX_PARITY_EN
        send_bit((^data) ^ p_odd ^ flip);
`endif
        send_bit(stop_ok);
        rxd = 1'b1;
        ack_armed = 1'b0;
        if (idle_bits > 0) wait_rises(idle_bits * OSR);
        model_frame(data, par_ok, stop_ok, acked);
    endtask

    task automatic check_all(input string tag);
        check({tag, ":data"}, 32'(rx_if.rx_data), 32'(m_data));
        check({tag, ":valid"}, 32'(rx_if.rx_valid), 32'(m_valid));
        check({tag, ":frame_err"}, 32'(n_ferr), 32'(m_ferr));
        check({tag, ":overrun"}, 32'(n_ovr), 32'(m_ovr));
`ifdef UART_RX_PARITY_EN
        check({tag, ":parity_err"}, 32'(n_perr), 32'(m_perr));
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        bit stop_ok, flip, acked;
        rx_if.rx_ack = 1'b0;

        // Reset state
        reset_n = 1'b0;
        repeat (4) step();
        check("rst:data", 32'(rx_if.rx_data), 32'h0);
        check("rst:valid", 32'(rx_if.rx_valid), 32'h0);
        check("rst:frame_err", 32'(rx_if.frame_err), 32'h0);
        check("rst:overrun", 32'(rx_if.overrun), 32'h0);
        check("rst:busy", 32'(busy), 32'h0);
        reset_n = 1'b1;
        repeat (4) step();

        // Reset in the middle of 0x55, then a clean 0xA3
        send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        check("mid:busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        rxd = 1'b1;
        repeat (3) step();
        reset_n = 1'b1;
        m_data = 8'h00; m_valid = 1'b0;
        repeat (4) step();
        check("midrst:busy", 32'(busy), 32'h0);
        check_all("midrst");
        frame(8'hA3, 1'b0, 1'b1, 0, 1'b0, -1);
        check_all("a3");
        do_ack();
        check("ack:valid", 32'(rx_if.rx_valid), 32'h0);

        // Slower rx_clk: tick every 4 clk, check latency of rx_valid
        half_per = 2;
        lat = -1;
        frame(8'h5A, 1'b0, 1'b1, 0, 1'b0, -1);
        check("lat:cycles", 32'(lat), 32'd1);
        check_all("5a");
        half_per = 1;
        do_ack();

        // Short low glitch on rxd
        rxd = 1'b0;
        wait_rises(3);
        rxd = 1'b1;
        wait_rises(20);
        check("glitch:busy", 32'(busy), 32'h0);
        check_all("glitch");

        // Bad stop bit, then a good frame
        frame(8'h3C, 1'b0, 1'b0, 2, 1'b0, -1);
        check_all("3c_badstop");
        frame(8'hC3, 1'b0, 1'b1, 0, 1'b0, -1);
        check_all("c3");
        do_ack();

        // Overrun, then ack on the completion cycle
        frame(8'h11, 1'b0, 1'b1, 0, 1'b0, -1);
        frame(8'h22, 1'b0, 1'b1, 0, 1'b0, -1);
        check_all("ovr");
        frame(8'h22, 1'b0, 1'b1, 0, 1'b1, -1);
        check_all("ack_same_cycle");
        do_ack();

        // rx_clk frozen mid-frame
        frame(8'h96, 1'b0, 1'b1, 0, 1'b0, 3);
        check_all("freeze");
        do_ack();

`ifdef UART_RX_PARITY_EN
        p_odd = 1'b0;
        frame(8'h07, 1'b0, 1'b1, 0, 1'b0, -1);
        check_all("par_ok");
        do_ack();
        frame(8'h07, 1'b1, 1'b1, 0, 1'b0, -1);
        check_all("par_bad");
        p_odd = 1'b1;
        frame(8'hE1, 1'b0, 1'b1, 0, 1'b0, -1);
        check_all("par_odd");
        do_ack();
`endif

        // Randomized frames: data, stop bit, parity, ack timing
        for (int k = 0; k < 12; k++) begin
            d       = 8'($urandom);
            stop_ok = ($urandom_range(3) != 0);
            flip    = (PAR_BITS != 0) && ($urandom_range(4) == 0);
            acked   = ($urandom_range(1) == 1);
            if ($urandom_range(1) == 1) do_ack();
            frame(d, flip, stop_ok, stop_ok ? 0 : 2, acked, -1);
            check_all($sformatf("rand%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
